// File: rtl/spi_pkg.sv
// Shared SPI link definitions: FSM encoding, command byte layout and frame lengths.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } spi_state_e;

  // Command byte: {rw, addr[6:0]}; rw=1 is a write.
  localparam logic        SPI_RW_WRITE = 1'b1;
  localparam int unsigned CMD_RW_BIT   = 7;
  localparam int unsigned CMD_ADDR_MSB = 6;
  localparam int unsigned CMD_ADDR_LSB = 0;

  localparam int unsigned BYTE_BITS    = 8;
  localparam int unsigned FRAME_BITS   = 16;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level with rise/fall pulses on the synced value.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: decodes {rw, addr} + data frames into register-bus strobes, returns reads on MISO.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              cs_ni,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              busy_o,
  output logic              frame_err_o
);

  localparam int unsigned     CntW    = $clog2(BYTE_BITS);
  localparam logic [CntW-1:0] LastBit = CntW'(BYTE_BITS - 1);

  logic sclk_rise, sclk_fall, unused_sclk_lvl;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sclk_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (sclk_i),
    .q_o   (unused_sclk_lvl),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  // cs_n resets to "selected" so a frame already under way at release produces no falling
  // edge; a fresh frame needs cs_n to be seen high first (tracked by armed_q).
  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_cs_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (cs_ni),
    .q_o   (cs_s),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  // Plain synchronizer for MOSI, same depth so it lines up with the sclk edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mosi_sync_q <= '0;
    else         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d, miso_q, miso_d;
  logic              we_q, we_d, re_q, re_d, load_q, load_d, err_q, err_d;
  logic              armed_q, armed_d;
  logic              sclk_rise_v, sclk_fall_v;
  logic [DATA_W-1:0] rx_byte;

  // Edges count while selected, plus the clk in which cs_n rises so a last bit still lands.
  assign sclk_rise_v = sclk_rise & (~cs_s | cs_rise);
  assign sclk_fall_v = sclk_fall & (~cs_s | cs_rise);
  assign rx_byte     = {rx_q[DATA_W-2:0], mosi_s};

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      miso_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      miso_q  <= miso_d;
      we_q    <= we_d;
      re_q    <= re_d;
      load_q  <= load_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

  // Frame FSM: command byte, then data bytes repeating with an auto-incrementing address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    miso_d  = miso_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    load_d  = re_q;
    err_d   = 1'b0;
    armed_d = armed_q | cs_s;

    // Read data is captured the clk after the strobe, well ahead of the next sclk fall.
    if (load_q) tx_d = reg_rdata_i;

    unique case (state_q)
      StIdle: begin
        if (cs_fall && armed_q) begin
          state_d = StCmd;
          cnt_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
          miso_d  = 1'b0;
        end
      end
      StCmd: begin
        if (sclk_rise_v) begin
          rx_d  = rx_byte;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            rw_d    = rx_byte[CMD_RW_BIT];
            addr_d  = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
            re_d    = (rx_byte[CMD_RW_BIT] != SPI_RW_WRITE);
            state_d = StData;
          end
        end
      end
      StData: begin
        // Write bursts advance the address one clk after the strobe used it.
        if (we_q && !cs_s) addr_d = addr_q + 1'b1;
        if (sclk_fall_v && rw_q != SPI_RW_WRITE) begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
        if (sclk_rise_v) begin
          rx_d  = rx_byte;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            if (rw_q == SPI_RW_WRITE) begin
              wdata_d = rx_byte;
              we_d    = 1'b1;
            end else if (!cs_s) begin
              addr_d = addr_q + 1'b1;
              re_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Deselect ends the frame from any state; a byte completing this same clk counts as clean.
    if (cs_rise) begin
      state_d = StIdle;
      miso_d  = 1'b0;
      if (state_q != StIdle && cnt_d != '0) err_d = 1'b1;
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = (state_q == StData) && (rw_q != SPI_RW_WRITE);
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = ~cs_s & armed_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Randomized bench for spi_slave_responder against a byte-level model of the register protocol.
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, reg_we, reg_re, busy, frame_err;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  spi_slave_responder #(
    .ADDR_W     (7),
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sclk_i     (sclk),
    .cs_ni      (cs_n),
    .mosi_i     (mosi),
    .miso_o     (miso),
    .miso_oe_o  (miso_oe),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_we_o   (reg_we),
    .reg_re_o   (reg_re),
    .reg_rdata_i(reg_rdata),
    .busy_o     (busy),
    .frame_err_o(frame_err)
  );

  // Register bank driven by the DUT's bus; ref_mem is the bench's own expectation.
  bit [7:0] bank[128];
  bit [7:0] ref_mem[128];
  assign reg_rdata = bank[reg_addr];
  always @(posedge clk) if (reg_we) bank[reg_addr] <= reg_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt, re_cnt, err_cnt, we_cyc, last_rise_cyc;
  logic [6:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  logic [6:0] re_addr_q[$];
  logic [7:0] fb[4];
  logic [7:0] mb[4];
  logic [7:0] ob[4];

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt++;
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
      we_cyc = cyc;
    end
    if (reg_re) begin
      re_cnt++;
      re_addr_q.push_back(reg_addr);
    end
    if (frame_err) err_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    we_cnt = 0;
    re_cnt = 0;
    err_cnt = 0;
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
    for (int i = 0; i < 4; i++) begin
      mb[i] = '0;
      ob[i] = '0;
    end
  endtask

  // One SPI bit at sclk = clk/8; MISO is sampled as the master would, at the rising edge.
  task automatic spi_bit(input logic b, input bit end_cs, output logic m, output logic oe);
    mosi = b;
    wait_clks(4);
    m = miso;
    oe = miso_oe;
    last_rise_cyc = cyc;
    sclk = 1'b1;
    if (end_cs) cs_n = 1'b1;
    wait_clks(4);
    sclk = 1'b0;
  endtask

  // Sends fb[0..nbytes-1]; cut_bits>0 stops the last byte early; same_end raises cs_n with
  // the final sclk rise.
  task automatic run_frame(input int nbytes, input int cut_bits, input bit same_end);
    logic m, oe;
    clear_mon();
    cs_n = 1'b0;
    wait_clks(8);
    for (int b = 0; b < nbytes; b++) begin
      int nb;
      nb = (cut_bits > 0 && b == nbytes - 1) ? cut_bits : 8;
      for (int i = 0; i < nb; i++) begin
        spi_bit(fb[b][7-i], same_end && b == nbytes - 1 && i == 7, m, oe);
        mb[b][7-i] = m;
        ob[b][7-i] = oe;
      end
    end
    wait_clks(4);
    cs_n = 1'b1;
    wait_clks(10);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " idle busy/oe/miso"}, {29'd0, busy, miso_oe, miso}, 32'd0);
  endtask

  // Write of nd bytes at a: one strobe per byte, address wrapping at 7 bits.
  task automatic check_write(input string tag, input int a, input int nd);
    check_val({tag, " we_cnt"}, we_cnt, nd);
    check_val({tag, " re_cnt"}, re_cnt, 0);
    check_val({tag, " err_cnt"}, err_cnt, 0);
    for (int i = 0; i < nd && i < we_addr_q.size(); i++) begin
      check_val($sformatf("%s we_addr[%0d]", tag, i), we_addr_q[i], (a + i) % 128);
      check_val($sformatf("%s we_data[%0d]", tag, i), we_data_q[i], fb[1+i]);
      ref_mem[(a + i) % 128] = fb[1+i];
    end
    for (int i = 0; i <= nd; i++) check_val($sformatf("%s oe[%0d]", tag, i), ob[i], 8'h00);
    check_idle(tag);
  endtask

  // Read of nd bytes at a: a strobe per address plus one prefetch for the byte after the last.
  task automatic check_read(input string tag, input int a, input int nd);
    check_val({tag, " re_cnt"}, re_cnt, nd + 1);
    check_val({tag, " we_cnt"}, we_cnt, 0);
    check_val({tag, " err_cnt"}, err_cnt, 0);
    for (int i = 0; i <= nd && i < re_addr_q.size(); i++)
      check_val($sformatf("%s re_addr[%0d]", tag, i), re_addr_q[i], (a + i) % 128);
    check_val({tag, " oe cmd"}, ob[0], 8'h00);
    for (int i = 0; i < nd; i++) begin
      check_val($sformatf("%s miso[%0d]", tag, i), mb[1+i], ref_mem[(a + i) % 128]);
      check_val($sformatf("%s oe[%0d]", tag, i + 1), ob[1+i], 8'hFF);
    end
    check_idle(tag);
  endtask

  initial begin
    logic m, oe;
    int a, nd;
    bit rw;

    // Reset state
    wait_clks(3);
    check_val("reset outputs",
              {11'd0, miso, miso_oe, reg_we, reg_re, busy, frame_err, reg_addr, reg_wdata}, 32'd0);
    rst_n = 1'b1;
    wait_clks(4);

    // Single write, plus strobe latency from the 16th sclk rise
    fb[0] = 8'h92;
    fb[1] = 8'hA5;
    run_frame(2, 0, 1'b0);
    check_write("wr12", 7'h12, 1);
    check_val("wr12 latency", we_cyc - last_rise_cyc, 3);

    // Read of a known value
    fb[0] = 8'h85;
    fb[1] = 8'h3C;
    run_frame(2, 0, 1'b0);
    check_write("wr05", 7'h05, 1);
    fb[0] = 8'h05;
    fb[1] = 8'($urandom);
    run_frame(2, 0, 1'b0);
    check_read("rd05", 7'h05, 1);
    check_val("rd05 byte", mb[1], 8'h3C);

    // Burst write across the address wrap
    fb[0] = 8'hFF;
    fb[1] = 8'h11;
    fb[2] = 8'h22;
    run_frame(3, 0, 1'b0);
    check_write("wrap", 7'h7F, 2);

    // Abort after 5 data bits
    fb[0] = 8'hB0;
    fb[1] = 8'($urandom);
    run_frame(2, 5, 1'b0);
    check_val("abort we_cnt", we_cnt, 0);
    check_val("abort err_cnt", err_cnt, 1);
    check_idle("abort");

    // Reset mid-command with cs_n still low at release
    clear_mon();
    cs_n = 1'b0;
    wait_clks(8);
    fb[0] = 8'hA1;
    for (int i = 0; i < 4; i++) spi_bit(fb[0][7-i], 1'b0, m, oe);
    rst_n = 1'b0;
    wait_clks(3);
    check_val("midrst outputs",
              {11'd0, miso, miso_oe, reg_we, reg_re, busy, frame_err, reg_addr, reg_wdata}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) spi_bit(1'($urandom), 1'b0, m, oe);
    wait_clks(4);
    cs_n = 1'b1;
    wait_clks(10);
    check_val("midrst strobes", {we_cnt[15:0], re_cnt[7:0], err_cnt[7:0]}, 32'd0);
    fb[0] = 8'hA1;
    fb[1] = 8'($urandom);
    run_frame(2, 0, 1'b0);
    check_write("postrst", 7'h21, 1);

    // cs_n rises together with the last sclk rise: clean end
    a = $urandom_range(0, 127);
    fb[0] = {1'b1, 7'(a)};
    fb[1] = 8'($urandom);
    run_frame(2, 0, 1'b1);
    check_write("sameclk", a, 1);

    // Random mix of write and read bursts
    for (int n = 0; n < 16; n++) begin
      rw = 1'($urandom);
      a = $urandom_range(0, 127);
      nd = $urandom_range(1, 3);
      fb[0] = {rw, 7'(a)};
      for (int i = 1; i < 4; i++) fb[i] = 8'($urandom);
      run_frame(nd + 1, 0, 1'b0);
      if (rw) check_write($sformatf("rnd%0d wr", n), a, nd);
      else    check_read($sformatf("rnd%0d rd", n), a, nd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
